// File: rtl/logic_basic_synchronizer_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : logic_basic_synchronizer_filter                                  |
// | Brief   : Per-channel multi-flop synchronizer, consecutive-cycle glitch    |
// |           filter and registered rise/fall pulse generation.                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module logic_basic_synchronizer_filter #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter int               FILTER      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int             CW      = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER - 1);

  for (genvar n = 0; n < WIDTH; n++) begin : g_ch
    logic [STAGES-1:0] sync_q;
    logic              s;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              o_q, o_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    assign s = sync_q[STAGES-1];

    // Any cycle where s matches o clears the count, so a glitch earns no credit.
    always_comb begin
      cnt_d  = '0;
      o_d    = o_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s != o_q) begin
        if (cnt_q == CNT_MAX) begin
          o_d    = s;
          rise_d = s;
          fall_d = ~s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
        sync_q <= {STAGES{RESET_VALUE[n]}};
        cnt_q  <= '0;
        o_q    <= RESET_VALUE[n];
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[STAGES-2:0], i[n]};
        cnt_q  <= cnt_d;
        o_q    <= o_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign o[n]    = o_q;
    assign rise[n] = rise_q;
    assign fall[n] = fall_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_basic_synchronizer_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_logic_basic_synchronizer_filter                               |
// | Brief   : Scoreboard bench: directed stimulus queues expected pulse events,|
// |           per-DUT monitors compare whenever rise/fall fire.                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_logic_basic_synchronizer_filter;

  typedef struct {
    int         cyc;
    logic [7:0] o;
    logic [7:0] r;
    logic [7:0] f;
  } exp_t;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic [7:0] i8 = 8'h05;
  logic [7:0] o8, rise8, fall8;
  logic [0:0] i1 = 1'b0;
  logic [0:0] o1, rise1, fall1;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Wide DUT: STAGES=2, FILTER=4, latency 6 edges from drive
  logic_basic_synchronizer_filter #(
    .WIDTH(8), .STAGES(2), .FILTER(4), .RESET_VALUE(8'h05)
  ) dut (
    .aclk(clk), .areset_n(areset_n), .i(i8), .o(o8), .rise(rise8), .fall(fall8)
  );

  // Degenerate DUT: STAGES=3, FILTER=1, latency 4 edges from drive
  logic_basic_synchronizer_filter #(
    .WIDTH(1), .STAGES(3), .FILTER(1), .RESET_VALUE(1'b0)
  ) dut1 (
    .aclk(clk), .areset_n(areset_n), .i(i1), .o(o1), .rise(rise1), .fall(fall1)
  );

  task automatic check(input string name, input logic ok, input int act, input int req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
  endtask

  task automatic push8(input int at, input logic [7:0] o, input logic [7:0] r, input logic [7:0] f);
    exp_t e;
    e.cyc = at; e.o = o; e.r = r; e.f = f;
    q8.push_back(e);
  endtask

  task automatic push1(input int at, input logic o, input logic r, input logic f);
    exp_t e;
    e.cyc = at; e.o = {7'd0, o}; e.r = {7'd0, r}; e.f = {7'd0, f};
    q1.push_back(e);
  endtask

  // Monitor for the wide DUT
  always @(negedge clk) begin
    exp_t e;
    if ((rise8 | fall8) != 8'h00) begin
      if (q8.size() == 0) begin
        check("w_unexpected_pulse", 1'b0, {rise8, fall8}, 0);
      end else begin
        e = q8.pop_front();
        check("w_pulse_cycle", cyc == e.cyc, cyc, e.cyc);
        check("w_o", o8 == e.o, o8, e.o);
        check("w_rise", rise8 == e.r, rise8, e.r);
        check("w_fall", fall8 == e.f, fall8, e.f);
      end
    end
  end

  // Monitor for the degenerate DUT
  always @(negedge clk) begin
    exp_t e;
    if ((rise1 | fall1) != 1'b0) begin
      if (q1.size() == 0) begin
        check("d_unexpected_pulse", 1'b0, {rise1, fall1}, 0);
      end else begin
        e = q1.pop_front();
        check("d_pulse_cycle", cyc == e.cyc, cyc, e.cyc);
        check("d_o", o1 == e.o[0], o1, e.o[0]);
        check("d_rise", rise1 == e.r[0], rise1, e.r[0]);
        check("d_fall", fall1 == e.f[0], fall1, e.f[0]);
      end
    end
  end

  initial begin
    int c;
    // Reset with the inputs already at the reset value
    repeat (3) @(negedge clk);
    check("rst_o", o8 == 8'h05, o8, 8'h05);
    check("rst_d_o", o1 == 1'b0, o1, 0);
    @(negedge clk) areset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("post_rst_quiet", o8 == 8'h05 && rise8 == 8'h00 && fall8 == 8'h00,
            {o8, rise8, fall8}, 24'h050000);
    end

    // Latency on channel 1
    @(negedge clk) i8 = 8'h07;
    push8(cyc + 6, 8'h07, 8'h02, 8'h00);
    repeat (12) @(negedge clk);

    // Glitch of 3 cycles on channel 3 is rejected
    @(negedge clk) i8 = 8'h0F;
    repeat (3) @(negedge clk);
    i8 = 8'h07;
    repeat (12) @(negedge clk);
    check("glitch_rejected", o8 == 8'h07, o8, 8'h07);

    // 4-cycle pulse passes: rise then fall 4 cycles later
    @(negedge clk) i8 = 8'h0F;
    c = cyc;
    push8(c + 6, 8'h0F, 8'h08, 8'h00);
    repeat (4) @(negedge clk);
    i8 = 8'h07;
    push8(c + 10, 8'h07, 8'h00, 8'h08);
    repeat (12) @(negedge clk);

    // Multi-channel simultaneous transitions
    @(negedge clk) i8 = 8'h00;
    push8(cyc + 6, 8'h00, 8'h00, 8'h07);
    repeat (12) @(negedge clk);
    @(negedge clk) i8 = 8'hA5;
    push8(cyc + 6, 8'hA5, 8'hA5, 8'h00);
    repeat (12) @(negedge clk);
    @(negedge clk) i8 = 8'h5A;
    push8(cyc + 6, 8'h5A, 8'h5A, 8'hA5);
    repeat (12) @(negedge clk);

    // Degenerate filter: toggle every 2 cycles
    for (int k = 0; k < 6; k++) begin
      @(negedge clk) i1 = ~i1;
      push1(cyc + 4, i1[0], i1[0], ~i1[0]);
      @(negedge clk);
    end
    repeat (8) @(negedge clk);

    // Reset in the middle of a pending count
    @(negedge clk) i8 = 8'hF2;
    repeat (4) @(negedge clk);
    #2 areset_n = 1'b0;
    #1;
    check("midrst_o", o8 == 8'h05, o8, 8'h05);
    check("midrst_pulses", rise8 == 8'h00 && fall8 == 8'h00, {rise8, fall8}, 0);
    @(negedge clk);
    @(negedge clk) areset_n = 1'b1;
    push8(cyc + 6, 8'hF2, 8'hF2, 8'h05);
    repeat (12) @(negedge clk);

    while (q8.size() != 0) begin
      exp_t e = q8.pop_front();
      check("w_missing_pulse", 1'b0, 0, e.cyc);
    end
    while (q1.size() != 0) begin
      exp_t e = q1.pop_front();
      check("d_missing_pulse", 1'b0, 0, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
